rotary_value_ctl: RTL and testbench
===================================

// Module: rotary_value_ctl
// PURPOSE
//  Controller between rotary-encoder event outputs (cw/ccw pulses) and the 8-bit seven-segment display driver.
//  Accumulates events into an 8-bit value using a programmable step, bounds and wrap/saturate mode.
//  Drives disp_value to the display. Exposes an Avalon-MM slave for CPU config and readback.
//  Raises an IRQ on every committed change.
// PARAMETERS
//  VAL_MIN       0    lower bound of value (0..255, VAL_MIN < VAL_MAX)
//  VAL_MAX       255  upper bound of value
//  ACCEL_WINDOW  2000 cycles; same-direction events closer than this are accelerated (ACCEL_EN only)
// PORTS
//  clk_clk        in   1   system clock
//  reset_reset    in   1   asynchronous, active-high reset
//  rotary_cw      in   1   1-cycle pulse, one clockwise detent
//  rotary_ccw     in   1   1-cycle pulse, one counter-clockwise detent
//  avs_address    in   2   register index
//  avs_read       in   1   read strobe
//  avs_write      in   1   write strobe
//  avs_writedata  in   32  write data
//  avs_readdata   out  32  read data, valid 1 cycle after avs_read
//  irq            out  1   level interrupt = STATUS.chg & CTRL.irq_en
//  disp_value     out  8   current value, to seven-seg driver
// BEHAVIOUR
//  Registers:
//   0 VALUE   R/W [7:0]; writes clamped to [VAL_MIN,VAL_MAX]; reset VAL_MIN
//   1 STEP    R/W [3:0]; write of 0 stored as 1; reset 1
//   2 CTRL    R/W bit0 wrap(1)/saturate(0), bit1 irq_en, bit2 enable; reset 0x4
//   3 STATUS  R: bit0 chg, bit1 ovf, [15:8] evcnt (mod 256); write 1 clears chg/ovf; write bit2=1 clears evcnt
//  Reset values: avs_readdata=0, irq=0, disp_value=VAL_MIN, FSM=IDLE, pending empty.
//  Event qualify: cw&ccw same cycle -> cancel, nothing recorded. CTRL.enable=0 -> events ignored.
//  FSM (one event in flight):
//   IDLE:   qualified event or pending valid -> latch dir, go CALC. Pending is consumed before a new event.
//   CALC:   next = value +/- STEP, computed 10-bit signed, then bounded -> COMMIT.
//   COMMIT: value<=next; chg<=1; evcnt++ -> IDLE.
//  Event-to-disp_value latency: 2 cycles (event in cycle N, disp_value updates at the edge ending N+2).
//  Bounding:
//   saturate: clamp to [VAL_MIN,VAL_MAX].
//   wrap: modulo range R=VAL_MAX-VAL_MIN+1, e.g. MIN=0,MAX=255 -> 254+3=1, 1-3=254.
//  Pending: single entry (direction + valid). Captures a qualified event arriving while FSM is in CALC/COMMIT,
//   or arriving in IDLE in the same cycle as a CPU VALUE write.
//   Event while pending already full -> dropped, STATUS.ovf<=1.
//  CPU VALUE write vs FSM:
//   write in CALC or COMMIT -> in-flight result discarded, written value stands, FSM -> IDLE, pending kept.
//   write in IDLE with an event -> write wins; event goes to pending and is applied on the written value.
//   CPU writes never set chg.
//  STATUS write-1-clear same cycle as COMMIT: the set wins, chg stays 1.
//  Reset mid-operation: all state returns to reset values immediately; in-flight and pending events are lost.
// CONFIGURATION
//  ACCEL_EN defined: cycle counter since last committed event. A same-direction event with counter < ACCEL_WINDOW
//   uses 4*STEP (10-bit signed, then bounded). Counter saturates at ACCEL_WINDOW and resets on each COMMIT.
//   STATUS bit2 reads 1 if the last commit was accelerated.
//  ACCEL_EN undefined: step is always STEP; no counter logic; STATUS bit2 reads 0.
// TESTING
//  1 Reset, 3 cw pulses 10 cycles apart, STEP=1 -> disp_value 0,1,2,3; each change 2 cycles after its pulse;
//    evcnt=3, chg=1.
//  2 VALUE=250, STEP=4, saturate, 3 cw -> 254,255,255. Then wrap, VALUE=254, STEP=3, cw -> 1;
//    then ccw -> 254.
//  3 cw & ccw asserted same cycle -> value unchanged, evcnt unchanged, chg stays 0.
//  4 cw at cycle N, ccw at N+1, cw at N+2 -> N+1 event goes to pending, N+2 event dropped with ovf=1;
//    final value = start.
//  5 VALUE write of 0x80 in the same cycle as cw, STEP=1 -> disp_value 0x80, then 0x81; chg=1;
//    CTRL.irq_en=1 -> irq=1; write STATUS=1 -> irq=0.
//  6 ACCEL_EN, STEP=2, 2 cw 100 cycles apart (WINDOW=2000) -> +2, +8. Third cw 3000 cycles later -> +2.

Source files
------------

// File: rtl/rotary_value_ctl.sv
// Rotary-encoder value controller: accumulates cw/ccw detents into a bounded 8-bit value with CPU access.
// Optional feature: define ACCEL_EN to enable same-direction acceleration (4*STEP within ACCEL_WINDOW cycles).
module rotary_value_ctl #(
    parameter int VAL_MIN      = 0,
    parameter int VAL_MAX      = 255,
    parameter int ACCEL_WINDOW = 2000
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        rotary_cw,
    input  logic        rotary_ccw,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        irq,
    output logic [7:0]  disp_value
);

    typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_t;

    localparam logic [7:0] MIN8  = 8'(VAL_MIN);
    localparam logic [7:0] MAX8  = 8'(VAL_MAX);
    localparam int         RANGE = VAL_MAX - VAL_MIN + 1;

    state_t      state_q;
    logic [7:0]  value_q, nextVal_q, nextVal_d;
    logic [3:0]  step_q;
    logic [2:0]  ctrl_q;
    logic        chg_q, ovf_q;
    logic [7:0]  evcnt_q;
    logic        dir_q, pendValid_q, pendDir_q;
    logic [31:0] readdata_q, readMux_d;
    logic [7:0]  wrClamped;
    logic [5:0]  stepEff;
    logic        accelFlag;

    logic evValid, evDir, valueWr, statusWr;
    logic unusedWd;

    assign evValid  = ctrl_q[2] & (rotary_cw ^ rotary_ccw);
    assign evDir    = rotary_cw;
    assign valueWr  = avs_write && (avs_address == 2'd0);
    assign statusWr = avs_write && (avs_address == 2'd3);
    assign unusedWd = ^avs_writedata[31:8];

    assign avs_readdata = readdata_q;
    assign disp_value   = value_q;
    assign irq          = chg_q & ctrl_q[1];

`ifdef ACCEL_EN
    localparam int CW = $clog2(ACCEL_WINDOW + 1);
    logic [CW-1:0] accelCnt_q;
    logic          accel_q, lastAccel_q, lastDir_q;
    assign stepEff   = accel_q ? {step_q, 2'b00} : {2'b00, step_q};
    assign accelFlag = lastAccel_q;
`else
    assign stepEff   = {2'b00, step_q};
    assign accelFlag = 1'b0;
`endif

    always_comb begin
        wrClamped = avs_writedata[7:0];
        if ($signed({2'b00, avs_writedata[7:0]}) < $signed(10'(VAL_MIN)))
            wrClamped = MIN8;
        else if ($signed({2'b00, avs_writedata[7:0]}) > $signed(10'(VAL_MAX)))
            wrClamped = MAX8;
    end

    always_comb begin
        case (avs_address)
            2'd0:    readMux_d = {24'd0, value_q};
            2'd1:    readMux_d = {28'd0, step_q};
            2'd2:    readMux_d = {29'd0, ctrl_q};
            default: readMux_d = {16'd0, evcnt_q, 5'd0, accelFlag, ovf_q, chg_q};
        endcase
    end

    // Next value: 10-bit signed sum, then saturated or wrapped modulo the range into [VAL_MIN,VAL_MAX]
    logic signed [9:0] sum, off;
    logic [9:0]        mag, rem;
    always_comb begin
        sum = dir_q ? ($signed({2'b00, value_q}) + $signed({4'b0000, stepEff}))
                    : ($signed({2'b00, value_q}) - $signed({4'b0000, stepEff}));
        off = sum - $signed(10'(VAL_MIN));
        mag = 10'd0;
        rem = 10'd0;
        nextVal_d = sum[7:0];
        if (ctrl_q[0]) begin
            if (off < 0) begin
                mag = $unsigned(-off - 10'sd1);
                rem = mag % 10'(RANGE);
                nextVal_d = MAX8 - rem[7:0];
            end else begin
                rem = $unsigned(off) % 10'(RANGE);
                nextVal_d = MIN8 + rem[7:0];
            end
        end else if (sum < $signed(10'(VAL_MIN))) begin
            nextVal_d = MIN8;
        end else if (sum > $signed(10'(VAL_MAX))) begin
            nextVal_d = MAX8;
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q     <= IDLE;
            value_q     <= MIN8;
            nextVal_q   <= MIN8;
            step_q      <= 4'd1;
            ctrl_q      <= 3'b100;
            chg_q       <= 1'b0;
            ovf_q       <= 1'b0;
            evcnt_q     <= 8'd0;
            dir_q       <= 1'b0;
            pendValid_q <= 1'b0;
            pendDir_q   <= 1'b0;
            readdata_q  <= 32'd0;
`ifdef ACCEL_EN
            accelCnt_q  <= CW'(ACCEL_WINDOW);
            accel_q     <= 1'b0;
            lastAccel_q <= 1'b0;
            lastDir_q   <= 1'b0;
`endif
        end else begin
            if (avs_read)
                readdata_q <= readMux_d;
            if (avs_write && avs_address == 2'd1)
                step_q <= (avs_writedata[3:0] == 4'd0) ? 4'd1 : avs_writedata[3:0];
            if (avs_write && avs_address == 2'd2)
                ctrl_q <= avs_writedata[2:0];
            // Clears come first so a same-cycle commit or overflow set overrides them
            if (statusWr) begin
                if (avs_writedata[0]) chg_q   <= 1'b0;
                if (avs_writedata[1]) ovf_q   <= 1'b0;
                if (avs_writedata[2]) evcnt_q <= 8'd0;
            end
`ifdef ACCEL_EN
            if (accelCnt_q < CW'(ACCEL_WINDOW))
                accelCnt_q <= accelCnt_q + CW'(1);
`endif
            // Events that cannot start now park in the single pending slot
            if (evValid && (state_q != IDLE || valueWr)) begin
                if (!pendValid_q) begin
                    pendValid_q <= 1'b1;
                    pendDir_q   <= evDir;
                end else begin
                    ovf_q <= 1'b1;
                end
            end
            case (state_q)
                IDLE: begin
                    if (valueWr) begin
                        value_q <= wrClamped;
                    end else if (pendValid_q) begin
                        dir_q   <= pendDir_q;
                        state_q <= CALC;
                        if (evValid)
                            pendDir_q <= evDir;
                        else
                            pendValid_q <= 1'b0;
`ifdef ACCEL_EN
                        accel_q <= (pendDir_q == lastDir_q) && (accelCnt_q < CW'(ACCEL_WINDOW));
`endif
                    end else if (evValid) begin
                        dir_q   <= evDir;
                        state_q <= CALC;
`ifdef ACCEL_EN
                        accel_q <= (evDir == lastDir_q) && (accelCnt_q < CW'(ACCEL_WINDOW));
`endif
                    end
                end
                CALC: begin
                    if (valueWr) begin
                        value_q <= wrClamped;
                        state_q <= IDLE;
                    end else begin
                        nextVal_q <= nextVal_d;
                        state_q   <= COMMIT;
                    end
                end
                COMMIT: begin
                    state_q <= IDLE;
                    if (valueWr) begin
                        value_q <= wrClamped;
                    end else begin
                        value_q <= nextVal_q;
                        chg_q   <= 1'b1;
                        evcnt_q <= evcnt_q + 8'd1;
`ifdef ACCEL_EN
                        accelCnt_q  <= CW'(0);
                        lastAccel_q <= accel_q;
                        lastDir_q   <= dir_q;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rotary_value_ctl.sv
// Scoreboard bench for rotary_value_ctl: stimulus pushes expected display/readback values,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_rotary_value_ctl;

    typedef struct {
        logic [7:0] v;
        int         cyc;
    } dispExp_t;

    logic        clk_clk = 1'b0;
    logic        reset_reset = 1'b1;
    logic        rotary_cw = 1'b0;
    logic        rotary_ccw = 1'b0;
    logic [1:0]  avs_address = 2'd0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = 32'd0;
    logic [31:0] avs_readdata;
    logic        irq;
    logic [7:0]  disp_value;

    int          checkCount = 0;
    int          passCount = 0;
    int          cycle = 0;
    logic        monitorOn = 1'b0;
    logic        rdSeen = 1'b0;
    logic [7:0]  lastDisp = 8'd0;
    dispExp_t    dispQ[$];
    logic [31:0] rdQ[$];

    rotary_value_ctl dut (
        .clk_clk(clk_clk),
        .reset_reset(reset_reset),
        .rotary_cw(rotary_cw),
        .rotary_ccw(rotary_ccw),
        .avs_address(avs_address),
        .avs_read(avs_read),
        .avs_write(avs_write),
        .avs_writedata(avs_writedata),
        .avs_readdata(avs_readdata),
        .irq(irq),
        .disp_value(disp_value)
    );

    always #5 clk_clk = ~clk_clk;

    always @(posedge clk_clk) begin
        cycle  <= cycle + 1;
        rdSeen <= avs_read;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp)
            passCount++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    endtask

    // Monitor: read data is presented the cycle after a read strobe; display changes are popped in order
    always @(negedge clk_clk) begin
        if (monitorOn) begin
            if (rdSeen) begin
                if (rdQ.size() == 0) begin
                    checkCount++;
                    $display("[TB] FAIL readdata: unexpected read response 0x%0h", avs_readdata);
                end else begin
                    checkOutput("readdata", avs_readdata, rdQ.pop_front());
                end
            end
            if (disp_value !== lastDisp) begin
                if (dispQ.size() == 0) begin
                    checkCount++;
                    $display("[TB] FAIL disp_value: unexpected change to 0x%0h, expected none", disp_value);
                end else begin
                    dispExp_t e;
                    e = dispQ.pop_front();
                    checkOutput("disp_value", {24'd0, disp_value}, {24'd0, e.v});
                    checkOutput("disp_latency", cycle, e.cyc);
                end
            end
            lastDisp = disp_value;
        end
    end

    task automatic applyStimulus(input logic cw, input logic ccw, input logic wr, input logic rd,
                                 input logic [1:0] addr, input logic [31:0] wdata);
        rotary_cw     = cw;
        rotary_ccw    = ccw;
        avs_write     = wr;
        avs_read      = rd;
        avs_address   = addr;
        avs_writedata = wdata;
        @(posedge clk_clk);
        #1;
        rotary_cw  = 1'b0;
        rotary_ccw = 1'b0;
        avs_write  = 1'b0;
        avs_read   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_clk);
        #1;
    endtask

    task automatic writeReg(input logic [1:0] addr, input logic [31:0] d);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, addr, d);
    endtask

    task automatic readReg(input logic [1:0] addr, input logic [31:0] exp);
        rdQ.push_back(exp);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, addr, 32'd0);
    endtask

    task automatic pushDisp(input logic [7:0] v, input int cyc);
        dispExp_t e;
        e.v   = v;
        e.cyc = cyc;
        dispQ.push_back(e);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        repeat (3) @(posedge clk_clk);
        #1;
        reset_reset = 1'b0;
        checkOutput("reset_disp", {24'd0, disp_value}, 32'd0);
        checkOutput("reset_irq", {31'd0, irq}, 32'd0);
        checkOutput("reset_readdata", avs_readdata, 32'd0);
        lastDisp  = disp_value;
        monitorOn = 1'b1;
        readReg(2'd3, 32'h0);
        readReg(2'd2, 32'h4);
        readReg(2'd1, 32'h1);

        // Three cw detents, STEP=1: display 1,2,3, each three edges after the drive point
        for (int i = 0; i < 3; i++) begin
            pushDisp(8'(i + 1), cycle + 3);
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
            idle(9);
        end
        readReg(2'd3, 32'h0301);
        readReg(2'd0, 32'd3);
        writeReg(2'd3, 32'h7);
        readReg(2'd3, 32'h0);

        // Saturate at the top, then wrap both ways
        writeReg(2'd1, 32'd4);
        writeReg(2'd2, 32'h4);
        pushDisp(8'd250, cycle + 1);
        writeReg(2'd0, 32'd250);
        pushDisp(8'd254, cycle + 3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
        idle(9);
        pushDisp(8'd255, cycle + 3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
        idle(9);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
        idle(9);
        readReg(2'd0, 32'd255);
        readReg(2'd3, 32'h0301);
        writeReg(2'd3, 32'h7);
        writeReg(2'd2, 32'h5);
        writeReg(2'd1, 32'd3);
        pushDisp(8'd254, cycle + 1);
        writeReg(2'd0, 32'd254);
        pushDisp(8'd1, cycle + 3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
        idle(9);
        pushDisp(8'd254, cycle + 3);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
        idle(9);

        // Simultaneous cw and ccw cancel
        writeReg(2'd3, 32'h7);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
        idle(5);
        readReg(2'd3, 32'h0);
        readReg(2'd0, 32'd254);

        // Back-to-back events: second pends, third overflows
        base = cycle;
        pushDisp(8'd1, base + 3);
        pushDisp(8'd254, base + 6);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
        idle(10);
        readReg(2'd3, 32'h0203);
        readReg(2'd0, 32'd254);

        // CPU write collides with an event: write wins, event applied afterwards
        writeReg(2'd3, 32'h7);
        writeReg(2'd2, 32'h7);
        writeReg(2'd1, 32'd1);
        base = cycle;
        pushDisp(8'h80, base + 1);
        pushDisp(8'h81, base + 4);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'h80);
        idle(6);
        checkOutput("irq_set", {31'd0, irq}, 32'd1);
        readReg(2'd3, 32'h0101);
        writeReg(2'd3, 32'h1);
        checkOutput("irq_clear", {31'd0, irq}, 32'd0);
        readReg(2'd3, 32'h0100);

        // STEP write of 0 becomes 1; saturate at the bottom; disabled encoder ignored
        writeReg(2'd1, 32'd0);
        readReg(2'd1, 32'd1);
        writeReg(2'd2, 32'h4);
        writeReg(2'd1, 32'd4);
        pushDisp(8'd2, cycle + 1);
        writeReg(2'd0, 32'd2);
        pushDisp(8'd0, cycle + 3);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
        idle(9);
        readReg(2'd0, 32'd0);
        writeReg(2'd2, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
        idle(9);
        readReg(2'd0, 32'd0);
        readReg(2'd2, 32'h0);

`ifdef ACCEL_EN
        // Acceleration: second cw within the window moves 4*STEP, a late one moves STEP
        writeReg(2'd2, 32'h4);
        writeReg(2'd1, 32'd2);
        pushDisp(8'd10, cycle + 1);
        writeReg(2'd0, 32'd10);
        pushDisp(8'd12, cycle + 3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
        idle(99);
        pushDisp(8'd20, cycle + 3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
        idle(9);
        readReg(2'd3, 32'h0405);
        idle(2990);
        pushDisp(8'd22, cycle + 3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
        idle(9);
        readReg(2'd3, 32'h0501);
`endif

        for (int i = 0; i < 50 && (dispQ.size() != 0 || rdQ.size() != 0); i++)
            idle(1);
        if (dispQ.size() != 0 || rdQ.size() != 0) begin
            checkCount++;
            $display("[TB] FAIL drain: %0d display and %0d read responses outstanding, expected 0",
                     dispQ.size(), rdQ.size());
        end
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
